// File: rtl/phrase_sequencer.sv
// phrase_sequencer
// Tempo-driven phrase player. Walks phrase-database entries first_addr..last_addr
// (wrapping modulo 2^ADDR_W) and emits one note code at a time, each held for
// SHORT_TICKS or LONG_TICKS tempo ticks depending on the note's length bit.
//
// Optional feature: define PHRASE_LOOP_EN to add the loop_en input. With loop_en=1
// the range restarts from first_addr on completion instead of finishing.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   tick           one-cycle tempo strobe
//   start, stop    begin playback of the latched range / abort playback
//   first_addr     first phrase of range
//   last_addr      last phrase of range
//   db_addr        address to phrase database (always the current pointer)
//   db_entry       packed note codes, note 0 in the most significant NOTE_W bits
//   length_entry   per-note length bits, MSB is note 0, 1 = long
//   n_note         number of notes in the entry minus 1
//   note           current note code
//   note_valid     a note is being played
//   note_strobe    pulse in the first cycle of each note
//   busy           fetching or playing
//   done           pulse on normal completion of the range
//   loop_en        (PHRASE_LOOP_EN only) restart the range on completion

`timescale 1ns/1ps

module phrase_sequencer #(
   parameter int unsigned NOTE_W      = 4,
   parameter int unsigned MAX_NOTES   = 8,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned CNT_W       = $clog2(MAX_NOTES),
   parameter int unsigned SHORT_TICKS = 1,
   parameter int unsigned LONG_TICKS  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick,
   input  logic                          start,
   input  logic                          stop,
   input  logic [ADDR_W-1:0]             first_addr,
   input  logic [ADDR_W-1:0]             last_addr,
   output logic [ADDR_W-1:0]             db_addr,
   input  logic [NOTE_W*MAX_NOTES-1:0]   db_entry,
   input  logic [MAX_NOTES-1:0]          length_entry,
   input  logic [CNT_W-1:0]              n_note,
   output logic [NOTE_W-1:0]             note,
   output logic                          note_valid,
   output logic                          note_strobe,
   output logic                          busy,
   output logic                          done
`ifdef PHRASE_LOOP_EN
   ,
   input  logic                          loop_en
`endif
);

   typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_e;

   state_e                        state_q, state_d;
   logic [ADDR_W-1:0]             ptr_q, ptr_d;
   logic [ADDR_W-1:0]             last_q, last_d;
`ifdef PHRASE_LOOP_EN
   logic [ADDR_W-1:0]             first_q, first_d;
`endif
   logic [NOTE_W*MAX_NOTES-1:0]   notes_q, notes_d;
   logic [MAX_NOTES-1:0]          lens_q, lens_d;
   logic [CNT_W-1:0]              nmax_q, nmax_d;
   logic [CNT_W-1:0]              idx_q, idx_d;
   logic [7:0]                    cnt_q, cnt_d;
   logic [NOTE_W-1:0]             note_q, note_d;
   logic                          strobe_q, strobe_d;
   logic                          done_q, done_d;

   // Note code of slot i; slot 0 sits in the most significant bits.
   function automatic logic [NOTE_W-1:0] slot_note(input logic [NOTE_W*MAX_NOTES-1:0] notes,
                                                   input logic [CNT_W-1:0] i);
      logic [NOTE_W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < MAX_NOTES; k++) begin
         if (CNT_W'(k) == i) r = notes[NOTE_W*(MAX_NOTES-1-k) +: NOTE_W];
      end
      return r;
   endfunction

   // Tick count for slot i; its length bit sits at MAX_NOTES-1-i.
   function automatic logic [7:0] slot_ticks(input logic [MAX_NOTES-1:0] lens,
                                             input logic [CNT_W-1:0] i);
      logic [7:0] r;
      r = 8'(SHORT_TICKS);
      for (int unsigned k = 0; k < MAX_NOTES; k++) begin
         if (CNT_W'(k) == i && lens[MAX_NOTES-1-k]) r = 8'(LONG_TICKS);
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         last_q   <= '0;
`ifdef PHRASE_LOOP_EN
         first_q  <= '0;
`endif
         notes_q  <= '0;
         lens_q   <= '0;
         nmax_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         note_q   <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         last_q   <= last_d;
`ifdef PHRASE_LOOP_EN
         first_q  <= first_d;
`endif
         notes_q  <= notes_d;
         lens_q   <= lens_d;
         nmax_q   <= nmax_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         note_q   <= note_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      last_d   = last_q;
`ifdef PHRASE_LOOP_EN
      first_d  = first_q;
`endif
      notes_d  = notes_q;
      lens_d   = lens_q;
      nmax_d   = nmax_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      note_d   = note_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            // start is ignored when stop arrives in the same cycle
            if (start && !stop) begin
`ifdef PHRASE_LOOP_EN
               first_d = first_addr;
`endif
               last_d  = last_addr;
               ptr_d   = first_addr;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (stop) begin
               state_d = StIdle;
            end else begin
               // Database is sampled only here; later changes do not touch this phrase.
               notes_d  = db_entry;
               lens_d   = length_entry;
               nmax_d   = n_note;
               idx_d    = '0;
               cnt_d    = slot_ticks(length_entry, '0);
               note_d   = slot_note(db_entry, '0);
               strobe_d = 1'b1;
               state_d  = StPlay;
            end
         end
         StPlay: begin
            if (stop) begin
               state_d = StIdle;
            end else if (tick) begin
               if (cnt_q > 8'd1) begin
                  cnt_d = cnt_q - 8'd1;
               end else if (idx_q != nmax_q) begin
                  idx_d    = idx_q + CNT_W'(1);
                  cnt_d    = slot_ticks(lens_q, idx_q + CNT_W'(1));
                  note_d   = slot_note(notes_q, idx_q + CNT_W'(1));
                  strobe_d = 1'b1;
               end else if (ptr_q != last_q) begin
                  // Natural overflow gives the wrap-around through 2^ADDR_W-1 to 0.
                  ptr_d   = ptr_q + ADDR_W'(1);
                  state_d = StFetch;
               end else begin
`ifdef PHRASE_LOOP_EN
                  if (loop_en) begin
                     ptr_d   = first_q;
                     state_d = StFetch;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
`else
                  state_d = StIdle;
                  done_d  = 1'b1;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign db_addr     = ptr_q;
   assign note        = note_q;
   assign note_valid  = (state_q == StPlay);
   assign note_strobe = strobe_q;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;

endmodule

// File: tb/tb_phrase_sequencer.sv
// Directed testbench for phrase_sequencer: single phrase, wrapping range, stop,
// asynchronous reset, ignored control inputs and (with PHRASE_LOOP_EN) looping.

`timescale 1ns/1ps

module tb_phrase_sequencer;

   typedef logic [3:0] nib_q_t[$];
   typedef int         int_q_t[$];

   logic        clk = 1'b0;
   logic        rst, tick, start, stop;
   logic [3:0]  first_addr, last_addr, db_addr;
   logic [31:0] db_entry;
   logic [7:0]  length_entry;
   logic [2:0]  n_note;
   logic [3:0]  note;
   logic        note_valid, note_strobe, busy, done;
`ifdef PHRASE_LOOP_EN
   logic        loop_en;
`endif

   int n_checks = 0;
   int n_errors = 0;

   phrase_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .start        (start),
      .stop         (stop),
      .first_addr   (first_addr),
      .last_addr    (last_addr),
      .db_addr      (db_addr),
      .db_entry     (db_entry),
      .length_entry (length_entry),
      .n_note       (n_note),
      .note         (note),
      .note_valid   (note_valid),
      .note_strobe  (note_strobe),
      .busy         (busy),
      .done         (done)
`ifdef PHRASE_LOOP_EN
      ,
      .loop_en      (loop_en)
`endif
   );

   always #5 clk = ~clk;

   // Phrase database: phrase 0 is the reference phrase; phrase a>0 plays a, a+1
   // with the second note long.
   always_comb begin
      if (db_addr == 4'd0) begin
         db_entry     = 32'h11272020;
         length_entry = 8'b10000000;
         n_note       = 3'd6;
      end else begin
         db_entry     = {db_addr, db_addr + 4'd1, 24'h0};
         length_entry = 8'b01000000;
         n_note       = 3'd1;
      end
   end

   // Tempo: a tick every 4 cycles, plus a forced tick for targeted cycles.
   logic tick_gen_en = 1'b0;
   logic tick_force  = 1'b0;
   initial begin
      int tphase;
      tphase = 0;
      tick   = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         tphase = (tphase + 1) % 4;
         tick   = (tick_gen_en && tphase == 0) || tick_force;
      end
   end

   // Monitor: per-note code, address and tick count; FETCH cycles; done pulses.
   logic [3:0] q_note[$];
   logic [3:0] q_addr[$];
   int         q_dur[$];
   int         cur_dur, n_strobe, n_done, n_fetch, done_bad;
   bit         dur_open;

   initial begin
      forever begin
         @(negedge clk);
         if (note_strobe) begin
            if (dur_open) q_dur.push_back(cur_dur);
            cur_dur  = 0;
            dur_open = 1'b1;
            q_note.push_back(note);
            q_addr.push_back(db_addr);
            n_strobe++;
         end
         if (note_valid && tick) cur_dur++;
         if (!note_valid && dur_open) begin
            q_dur.push_back(cur_dur);
            dur_open = 1'b0;
         end
         if (busy && !note_valid) n_fetch++;
         if (done) begin
            n_done++;
            if (busy || note_valid) done_bad++;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      q_note.delete();
      q_addr.delete();
      q_dur.delete();
      cur_dur  = 0;
      dur_open = 1'b0;
      n_strobe = 0;
      n_done   = 0;
      n_fetch  = 0;
      done_bad = 0;
   endtask

   nib_q_t exp_note, exp_addr;
   int_q_t exp_dur;

   task automatic clear_exp();
      exp_note.delete();
      exp_addr.delete();
      exp_dur.delete();
   endtask

   task automatic add_phrase(input logic [3:0] a);
      logic [3:0] p0_notes[7] = '{4'd1, 4'd1, 4'd2, 4'd7, 4'd2, 4'd0, 4'd2};
      int         p0_durs[7]  = '{2, 1, 1, 1, 1, 1, 1};
      if (a == 4'd0) begin
         for (int i = 0; i < 7; i++) begin
            exp_note.push_back(p0_notes[i]);
            exp_dur.push_back(p0_durs[i]);
            exp_addr.push_back(4'd0);
         end
      end else begin
         exp_note.push_back(a);
         exp_note.push_back(a + 4'd1);
         exp_dur.push_back(1);
         exp_dur.push_back(2);
         exp_addr.push_back(a);
         exp_addr.push_back(a);
      end
   endtask

   task automatic check_seq(input string tag);
      check_eq({tag, " note count"}, q_note.size(), exp_note.size());
      for (int i = 0; i < exp_note.size(); i++) begin
         if (i < q_note.size()) begin
            check_eq($sformatf("%s note %0d", tag, i), q_note[i], exp_note[i]);
            check_eq($sformatf("%s addr %0d", tag, i), q_addr[i], exp_addr[i]);
            check_eq($sformatf("%s dur %0d", tag, i),
                     (i < q_dur.size()) ? q_dur[i] : -1, exp_dur[i]);
         end
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && n_done == 0; i++) @(negedge clk);
      check_eq({tag, " done seen"}, (n_done > 0), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_strobes(input string tag, input int count, input int budget);
      for (int i = 0; i < budget && n_strobe < count; i++) @(negedge clk);
      check_eq({tag, " strobes reached"}, (n_strobe >= count), 1);
   endtask

   // Pulse start for one cycle; returns just after the sampling edge (FETCH cycle).
   task automatic pulse_start(input logic [3:0] f, input logic [3:0] l);
      @(posedge clk);
      #1;
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      first_addr = 4'd0;
      last_addr  = 4'd0;
`ifdef PHRASE_LOOP_EN
      loop_en    = 1'b0;
`endif
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset busy", busy, 0);
      check_eq("reset note_valid", note_valid, 0);
      check_eq("reset note", note, 0);
      check_eq("reset db_addr", db_addr, 0);
      check_eq("reset done", done, 0);
      check_eq("reset strobe", note_strobe, 0);
      rst         = 1'b0;
      tick_gen_en = 1'b1;

      // start+stop together, and stop alone, in IDLE do nothing
      @(posedge clk);
      #1;
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      check_eq("start+stop idle busy", busy, 0);
      check_eq("start+stop idle fetch", n_fetch, 0);

      // Single phrase 0, with a tick forced during FETCH and a start while busy
      clear_mon();
      pulse_start(4'd0, 4'd0);
      tick_force = 1'b1;
      @(negedge clk);
      check_eq("k+1 busy", busy, 1);
      check_eq("k+1 note_valid", note_valid, 0);
      check_eq("k+1 db_addr", db_addr, 0);
      @(posedge clk);
      #1;
      tick_force = 1'b0;
      @(negedge clk);
      check_eq("k+2 note_valid", note_valid, 1);
      check_eq("k+2 strobe", note_strobe, 1);
      check_eq("k+2 note", note, 1);
      repeat (5) @(posedge clk);
      #1;
      first_addr = 4'd5;
      last_addr  = 4'd5;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("p0", 600);
      clear_exp();
      add_phrase(4'd0);
      check_seq("p0");
      check_eq("p0 done count", n_done, 1);
      check_eq("p0 done cycle idle", done_bad, 0);
      check_eq("p0 fetch cycles", n_fetch, 1);
      check_eq("p0 busy after", busy, 0);
      check_eq("p0 note holds", note, 2);

      // Wrapping range 14..1
      clear_mon();
      pulse_start(4'd14, 4'd1);
      wait_done("wrap", 1200);
      clear_exp();
      add_phrase(4'd14);
      add_phrase(4'd15);
      add_phrase(4'd0);
      add_phrase(4'd1);
      check_seq("wrap");
      check_eq("wrap fetch cycles", n_fetch, 4);
      check_eq("wrap done count", n_done, 1);
      check_eq("wrap done cycle idle", done_bad, 0);

      // stop during the third note, then replay from note 0
      clear_mon();
      pulse_start(4'd0, 4'd0);
      wait_strobes("stop", 3, 300);
      @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      check_eq("stop busy", busy, 0);
      check_eq("stop note_valid", note_valid, 0);
      repeat (12) @(negedge clk);
      check_eq("stop no done", n_done, 0);
      check_eq("stop strobes", n_strobe, 3);
      clear_mon();
      pulse_start(4'd0, 4'd0);
      wait_done("replay", 600);
      clear_exp();
      add_phrase(4'd0);
      check_seq("replay");
      check_eq("replay done count", n_done, 1);

      // Asynchronous reset mid-PLAY; start and tick during reset are ignored
      clear_mon();
      pulse_start(4'd0, 4'd0);
      wait_strobes("rst", 2, 300);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("rst busy", busy, 0);
      check_eq("rst note_valid", note_valid, 0);
      check_eq("rst note", note, 0);
      check_eq("rst db_addr", db_addr, 0);
      check_eq("rst strobe", note_strobe, 0);
      check_eq("rst done", done, 0);
      first_addr = 4'd3;
      start      = 1'b1;
      tick_force = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst        = 1'b0;
      start      = 1'b0;
      tick_force = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("post-rst busy", busy, 0);
      check_eq("post-rst no done", n_done, 0);

`ifdef PHRASE_LOOP_EN
      // Loop over 0..1, then drop loop_en during the second pass of phrase 1
      clear_mon();
      loop_en = 1'b1;
      pulse_start(4'd0, 4'd1);
      wait_strobes("loop", 18, 1500);
      check_eq("loop no done yet", n_done, 0);
      @(posedge clk);
      #1;
      loop_en = 1'b0;
      wait_done("loop", 600);
      clear_exp();
      add_phrase(4'd0);
      add_phrase(4'd1);
      add_phrase(4'd0);
      add_phrase(4'd1);
      check_seq("loop");
      check_eq("loop fetch cycles", n_fetch, 4);
      check_eq("loop done count", n_done, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
